decode_stage_riscv: RTL and testbench
=====================================

Name: decode_stage_riscv

Overview:
Registered, parametrised RV32I decode stage that replaces the bare combinational decoder in the core pipeline. It sits between fetch and execute. It accepts one instruction and its PC per valid/ready handshake and decodes the full base ISA, plus Zicsr when enabled. Results are held in a two-entry skid buffer so execute back-pressure never creates a combinational ready path to fetch. It also supports a pipeline flush.

Parameters:
PC_W, 32, width of the PC passed through with each instruction.
EN_CSR, 0, 1 = decode Zicsr instructions; 0 = all CSR instructions are illegal.
EN_FENCE_NOP, 1, 1 = FENCE/FENCE.I decode as NOP; 0 = MISC_MEM is illegal.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  synchronous, active-low reset.
flush_i  in  1  drop all held entries; ignore any input offered this cycle.
in_valid_i  in  1  fetch presents an instruction.
in_ready_o  out  1  stage can accept; registered, equals !skid_valid.
in_instr_i  in  32  instruction word.
in_pc_i  in  PC_W  instruction PC.
out_valid_o  out  1  decoded entry available.
out_ready_i  in  1  execute consumes the entry.
out_pc_o  out  PC_W  PC of the entry.
out_instr_o  out  32  raw instruction, for immediate extraction.
ex_op_a_sel_o  out  2  operand A select (OP_A_* encodings).
ex_op_b_sel_o  out  3  operand B select (OP_B_* encodings).
alu_op_o  out  5  ALU operation (ALU_* encodings).
mem_req_o  out  1  memory access.
mem_we_o  out  1  store.
mem_size_o  out  3  access size (LDST_* encodings, equal to funct3).
gpr_we_a_o  out  1  register-file write.
wb_src_sel_o  out  1  WB_EX_RESULT or WB_LSU_DATA.
branch_o, jal_o, jalr_o  out  1 each  control-flow class.
csr_op_o  out  3  funct3 for CSR ops; 0 otherwise.
ecall_o, ebreak_o, mret_o  out  1 each  system events.
illegal_instr_o  out  1  instruction is illegal.

Behaviour:
- Reset (rst_ni=0 at a clock edge): main_valid and skid_valid are cleared, so out_valid_o=0 and in_ready_o=1. The decoded payload resets to the NOP bundle: OP_A_RS1, OP_B_IMM_I, ALU_ADD, LDST_B, WB_EX_RESULT, and every enable/flag 0. out_pc_o and out_instr_o reset to 0. Reset takes priority over flush and over any handshake.
- Decode is combinational on in_instr_i and is captured in the same cycle the handshake fires.
- Latency: an instruction accepted at edge N is on out_* with out_valid_o=1 after edge N, provided the stage was empty.
- Accept: in_valid_i && in_ready_o && !flush_i. Consume: out_valid_o && out_ready_i.
- Storage: a main register drives the outputs; a skid register holds one extra entry.
  - Main empty, or consumed this cycle: the incoming entry goes to main, or the skid entry moves to main if skid is valid.
  - Main full and not consumed: the incoming entry goes to skid.
  - Simultaneous accept and consume with skid valid: skid moves to main and the incoming entry goes to skid.
  - Order is always preserved.
- in_ready_o is registered: it is low exactly while skid_valid=1.
- flush_i=1: both valid bits clear at the next edge and the input is not accepted. A consume in the same cycle is still seen by execute.
- Decode table: opcode[1:0]!=2'b11, or an unlisted opcode, is illegal.
  - LOAD: funct3 3, 6 or 7 is illegal.
  - STORE: funct3 >2 is illegal.
  - BRANCH: funct3 2 or 3 is illegal.
  - JALR: funct3!=0 is illegal.
  - OP_IMM: SLLI needs funct7=0. SRLI/SRAI need funct7 of 0x00 or 0x20.
  - OP: funct7 must be 0x00, or 0x20 only for ADD→SUB and SRL→SRA.
  - LUI: operand A is OP_A_ZERO. AUIPC: operand A is OP_A_CURR_PC.
  - JAL/JALR: operand A is OP_A_CURR_PC, operand B is OP_B_INCR, gpr_we=1.
  - MISC_MEM: governed by EN_FENCE_NOP.
  - SYSTEM exact words: 0x00000073 is ECALL, 0x00100073 is EBREAK, 0x30200073 is MRET. CSR funct3 values 1–3 and 5–7 are legal only when EN_CSR=1, and then gpr_we=1. Any other SYSTEM word is illegal.
- An illegal instruction forces mem_req, mem_we, gpr_we, branch, jal, jalr, csr_op and the system flags to 0.
- Loads: mem_size_o=funct3, mem_req=1, wb=WB_LSU_DATA.
  - This corrects the old decoder's behaviour of driving mem_req from the size value.

Decomposition:
- Package riscv_decode_pkg holds:
  - opcode, ALU_*, OP_A_*, OP_B_*, LDST_*, WB_* localparams, migrated from defines_riscv.v;
  - the decoded_t packed struct (all control fields);
  - the NOP_DECODE constant.
- Sub-module decoder_riscv_core: purely combinational, instr → decoded_t, parameterised by EN_CSR and EN_FENCE_NOP.
- The stage instantiates decoder_riscv_core plus the skid logic.

Test Plan:
- Reset with in_valid_i=1 → out_valid_o=0, in_ready_o=1, payload equals NOP_DECODE. Release: 0x00412083 (lw x1,4(x2)) → next cycle mem_req=1, mem_we=0, mem_size=LDST_W, gpr_we=1, wb=WB_LSU_DATA.
- 0x00112223 (sw), 0x40208033 (sub), 0x0000006F (jal) back-to-back with out_ready_i=1 → one result per cycle, in order: mem_we=1; alu_op=ALU_SUB; jal_o=1 with OP_B_INCR.
- Illegal words 0x00000000, 0x00003083 (ld), 0x02000033 (funct7=1) → illegal_instr_o=1 and all enables 0.
- out_ready_i=0 with 3 instructions offered → first two accepted, in_ready_o=0 after the second. Release → outputs in order A, B, C with no drop or duplicate.
- Skid full, flush_i=1 → next cycle out_valid_o=0, in_ready_o=1. The word offered during the flush never appears.
- EN_CSR=0: 0x30002073 (csrrs) → illegal. EN_CSR=1: same word → csr_op_o=2, gpr_we=1. 0x30200073 → mret_o=1 in both configurations.

Source files
------------

// File: rtl/riscv_decode_pkg.sv
// Shared encodings and the decoded control bundle for the RV32I decode stage.
// Field encodings follow the legacy core so execute/LSU need no changes.
package riscv_decode_pkg;

    // opcode[6:2]; opcode[1:0] must be 2'b11
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLTS = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_EQ   = 5'b11000;
    localparam logic [4:0] ALU_NE   = 5'b11001;
    localparam logic [4:0] ALU_LTS  = 5'b11100;
    localparam logic [4:0] ALU_GES  = 5'b11101;
    localparam logic [4:0] ALU_LTU  = 5'b11110;
    localparam logic [4:0] ALU_GEU  = 5'b11111;

    localparam logic [1:0] OP_A_RS1     = 2'd0;
    localparam logic [1:0] OP_A_CURR_PC = 2'd1;
    localparam logic [1:0] OP_A_ZERO    = 2'd2;

    localparam logic [2:0] OP_B_RS2   = 3'd0;
    localparam logic [2:0] OP_B_IMM_I = 3'd1;
    localparam logic [2:0] OP_B_IMM_U = 3'd2;
    localparam logic [2:0] OP_B_IMM_S = 3'd3;
    localparam logic [2:0] OP_B_INCR  = 3'd4;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam logic WB_EX_RESULT = 1'b0;
    localparam logic WB_LSU_DATA  = 1'b1;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    typedef struct packed {
        logic [1:0] op_a_sel;
        logic [2:0] op_b_sel;
        logic [4:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       gpr_we;
        logic       wb_src_sel;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [2:0] csr_op;
        logic       ecall;
        logic       ebreak;
        logic       mret;
        logic       illegal;
    } decoded_t;

    localparam decoded_t NOP_DECODE = '{
        op_a_sel:   OP_A_RS1,
        op_b_sel:   OP_B_IMM_I,
        alu_op:     ALU_ADD,
        mem_req:    1'b0,
        mem_we:     1'b0,
        mem_size:   LDST_B,
        gpr_we:     1'b0,
        wb_src_sel: WB_EX_RESULT,
        branch:     1'b0,
        jal:        1'b0,
        jalr:       1'b0,
        csr_op:     3'd0,
        ecall:      1'b0,
        ebreak:     1'b0,
        mret:       1'b0,
        illegal:    1'b0
    };

endpackage

// File: rtl/decode_stage_riscv_core.sv
// Purely combinational RV32I (+ optional Zicsr) decoder: instruction word -> decoded_t.
module decoder_riscv_core
    import riscv_decode_pkg::*;
#(
    parameter int unsigned EN_CSR       = 0,
    parameter int unsigned EN_FENCE_NOP = 1
) (
    input  logic [31:0] i_instr,
    output decoded_t    o_dec
);

    logic [4:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_illegal;
    decoded_t   w_dec;

    assign w_opcode = i_instr[6:2];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    always_comb begin
        w_dec     = NOP_DECODE;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_LOAD: begin
                w_dec.mem_req    = 1'b1;
                w_dec.mem_size   = w_funct3;
                w_dec.gpr_we     = 1'b1;
                w_dec.wb_src_sel = WB_LSU_DATA;
                w_illegal        = (w_funct3 == 3'd3) || (w_funct3 > 3'd5);
            end
            OPC_STORE: begin
                w_dec.op_b_sel = OP_B_IMM_S;
                w_dec.mem_req  = 1'b1;
                w_dec.mem_we   = 1'b1;
                w_dec.mem_size = w_funct3;
                w_illegal      = (w_funct3 > 3'd2);
            end
            OPC_BRANCH: begin
                w_dec.op_b_sel = OP_B_RS2;
                w_dec.branch   = 1'b1;
                case (w_funct3)
                    3'd0:    w_dec.alu_op = ALU_EQ;
                    3'd1:    w_dec.alu_op = ALU_NE;
                    3'd4:    w_dec.alu_op = ALU_LTS;
                    3'd5:    w_dec.alu_op = ALU_GES;
                    3'd6:    w_dec.alu_op = ALU_LTU;
                    3'd7:    w_dec.alu_op = ALU_GEU;
                    default: w_illegal    = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                w_dec.op_a_sel = OP_A_CURR_PC;
                w_dec.op_b_sel = OP_B_INCR;
                w_dec.gpr_we   = 1'b1;
                w_dec.jal      = (w_opcode == OPC_JAL);
                w_dec.jalr     = (w_opcode == OPC_JALR);
                w_illegal      = (w_opcode == OPC_JALR) && (w_funct3 != 3'd0);
            end
            OPC_OP_IMM, OPC_OP: begin
                w_dec.gpr_we   = 1'b1;
                w_dec.op_b_sel = (w_opcode == OPC_OP) ? OP_B_RS2 : OP_B_IMM_I;
                w_dec.alu_op   = {2'b00, w_funct3};
                if (w_funct7 == 7'h20 && (w_funct3 == 3'd5 ||
                        (w_funct3 == 3'd0 && w_opcode == OPC_OP))) begin
                    w_dec.alu_op = (w_funct3 == 3'd0) ? ALU_SUB : ALU_SRA;
                end else if (w_funct7 != 7'h00 &&
                        (w_opcode == OPC_OP || w_funct3 == 3'd1 || w_funct3 == 3'd5)) begin
                    // funct7 is immediate bits for non-shift OP_IMM, so only shifts check it
                    w_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                w_dec.op_a_sel = OP_A_ZERO;
                w_dec.op_b_sel = OP_B_IMM_U;
                w_dec.gpr_we   = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.op_a_sel = OP_A_CURR_PC;
                w_dec.op_b_sel = OP_B_IMM_U;
                w_dec.gpr_we   = 1'b1;
            end
            OPC_MISC_MEM: w_illegal = (EN_FENCE_NOP == 0);
            OPC_SYSTEM: begin
                if (i_instr == INSTR_ECALL) begin
                    w_dec.ecall = 1'b1;
                end else if (i_instr == INSTR_EBREAK) begin
                    w_dec.ebreak = 1'b1;
                end else if (i_instr == INSTR_MRET) begin
                    w_dec.mret = 1'b1;
                end else if (EN_CSR != 0 && w_funct3 != 3'd0 && w_funct3 != 3'd4) begin
                    w_dec.csr_op = w_funct3;
                    w_dec.gpr_we = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase

        if (i_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end
        if (w_illegal) begin
            w_dec         = NOP_DECODE;
            w_dec.illegal = 1'b1;
        end
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/decode_stage_riscv.sv
// Registered RV32I decode stage: combinational decode captured into a two-entry skid buffer
// so that in_ready_o is a flop and never depends combinationally on out_ready_i.
module decode_stage_riscv
    import riscv_decode_pkg::*;
#(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned EN_CSR       = 0,
    parameter int unsigned EN_FENCE_NOP = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [PC_W-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PC_W-1:0] out_pc_o,
    output logic [31:0]     out_instr_o,
    output logic [1:0]      ex_op_a_sel_o,
    output logic [2:0]      ex_op_b_sel_o,
    output logic [4:0]      alu_op_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [2:0]      mem_size_o,
    output logic            gpr_we_a_o,
    output logic            wb_src_sel_o,
    output logic            branch_o,
    output logic            jal_o,
    output logic            jalr_o,
    output logic [2:0]      csr_op_o,
    output logic            ecall_o,
    output logic            ebreak_o,
    output logic            mret_o,
    output logic            illegal_instr_o
);

    decoded_t        w_in_dec;
    logic            w_accept;
    logic            w_consume;

    logic            r_main_valid;
    logic [PC_W-1:0] r_main_pc;
    logic [31:0]     r_main_instr;
    decoded_t        r_main_dec;
    logic            r_skid_valid;
    logic [PC_W-1:0] r_skid_pc;
    logic [31:0]     r_skid_instr;
    decoded_t        r_skid_dec;

    decoder_riscv_core #(
        .EN_CSR       (EN_CSR),
        .EN_FENCE_NOP (EN_FENCE_NOP)
    ) u_core (
        .i_instr (in_instr_i),
        .o_dec   (w_in_dec)
    );

    assign in_ready_o = !r_skid_valid;
    assign w_accept   = in_valid_i && in_ready_o && !flush_i;
    assign w_consume  = r_main_valid && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_main_valid <= 1'b0;
            r_main_pc    <= '0;
            r_main_instr <= '0;
            r_main_dec   <= NOP_DECODE;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_dec   <= NOP_DECODE;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_consume) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_pc    <= r_skid_pc;
                r_main_instr <= r_skid_instr;
                r_main_dec   <= r_skid_dec;
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid_pc    <= in_pc_i;
                    r_skid_instr <= in_instr_i;
                    r_skid_dec   <= w_in_dec;
                end
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_pc    <= in_pc_i;
                    r_main_instr <= in_instr_i;
                    r_main_dec   <= w_in_dec;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_pc    <= in_pc_i;
            r_skid_instr <= in_instr_i;
            r_skid_dec   <= w_in_dec;
        end
    end

    assign out_valid_o     = r_main_valid;
    assign out_pc_o        = r_main_pc;
    assign out_instr_o     = r_main_instr;
    assign ex_op_a_sel_o   = r_main_dec.op_a_sel;
    assign ex_op_b_sel_o   = r_main_dec.op_b_sel;
    assign alu_op_o        = r_main_dec.alu_op;
    assign mem_req_o       = r_main_dec.mem_req;
    assign mem_we_o        = r_main_dec.mem_we;
    assign mem_size_o      = r_main_dec.mem_size;
    assign gpr_we_a_o      = r_main_dec.gpr_we;
    assign wb_src_sel_o    = r_main_dec.wb_src_sel;
    assign branch_o        = r_main_dec.branch;
    assign jal_o           = r_main_dec.jal;
    assign jalr_o          = r_main_dec.jalr;
    assign csr_op_o        = r_main_dec.csr_op;
    assign ecall_o         = r_main_dec.ecall;
    assign ebreak_o        = r_main_dec.ebreak;
    assign mret_o          = r_main_dec.mret;
    assign illegal_instr_o = r_main_dec.illegal;

endmodule

// File: tb/tb_decode_stage_riscv.sv
// Directed bench for decode_stage_riscv; a second instance with EN_CSR=1 shares the stimulus.
module tb_decode_stage_riscv;
    import riscv_decode_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic [31:0] in_instr_i;
    logic [31:0] in_pc_i;
    logic        out_ready_i;

    logic        in_ready_o, out_valid_o;
    logic [31:0] out_pc_o, out_instr_o;
    logic [1:0]  ex_op_a_sel_o;
    logic [2:0]  ex_op_b_sel_o, mem_size_o, csr_op_o;
    logic [4:0]  alu_op_o;
    logic        mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o, branch_o, jal_o, jalr_o;
    logic        ecall_o, ebreak_o, mret_o, illegal_instr_o;

    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_pc, c_out_instr;
    logic [1:0]  c_op_a;
    logic [2:0]  c_op_b, c_mem_size, c_csr_op;
    logic [4:0]  c_alu;
    logic        c_mem_req, c_mem_we, c_gpr_we, c_wb, c_branch, c_jal, c_jalr;
    logic        c_ecall, c_ebreak, c_mret, c_illegal;

    decoded_t    obs;
    logic [11:0] enables;
    int          n_err;
    int          n_chk;

    decode_stage_riscv #(.PC_W(32), .EN_CSR(0), .EN_FENCE_NOP(1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
        .ex_op_a_sel_o(ex_op_a_sel_o), .ex_op_b_sel_o(ex_op_b_sel_o), .alu_op_o(alu_op_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
        .gpr_we_a_o(gpr_we_a_o), .wb_src_sel_o(wb_src_sel_o),
        .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o), .csr_op_o(csr_op_o),
        .ecall_o(ecall_o), .ebreak_o(ebreak_o), .mret_o(mret_o),
        .illegal_instr_o(illegal_instr_o)
    );

    decode_stage_riscv #(.PC_W(32), .EN_CSR(1), .EN_FENCE_NOP(1)) dut_csr (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(c_in_ready),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(c_out_valid), .out_ready_i(out_ready_i),
        .out_pc_o(c_out_pc), .out_instr_o(c_out_instr),
        .ex_op_a_sel_o(c_op_a), .ex_op_b_sel_o(c_op_b), .alu_op_o(c_alu),
        .mem_req_o(c_mem_req), .mem_we_o(c_mem_we), .mem_size_o(c_mem_size),
        .gpr_we_a_o(c_gpr_we), .wb_src_sel_o(c_wb),
        .branch_o(c_branch), .jal_o(c_jal), .jalr_o(c_jalr), .csr_op_o(c_csr_op),
        .ecall_o(c_ecall), .ebreak_o(c_ebreak), .mret_o(c_mret),
        .illegal_instr_o(c_illegal)
    );

    assign obs = '{op_a_sel: ex_op_a_sel_o, op_b_sel: ex_op_b_sel_o, alu_op: alu_op_o,
                   mem_req: mem_req_o, mem_we: mem_we_o, mem_size: mem_size_o,
                   gpr_we: gpr_we_a_o, wb_src_sel: wb_src_sel_o, branch: branch_o,
                   jal: jal_o, jalr: jalr_o, csr_op: csr_op_o, ecall: ecall_o,
                   ebreak: ebreak_o, mret: mret_o, illegal: illegal_instr_o};
    assign enables = {mem_req_o, mem_we_o, gpr_we_a_o, branch_o, jal_o, jalr_o, csr_op_o,
                      ecall_o, ebreak_o, mret_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b1;
        in_instr_i  = 32'h0041_2083;
        in_pc_i     = 32'h0000_0100;
        out_ready_i = 1'b1;
        tick();
        tick();
        n_chk++;
        if (out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid_o);
        end
        n_chk++;
        if (in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready_o);
        end
        n_chk++;
        if (obs !== NOP_DECODE) begin
            n_err++; $display("FAIL reset_payload: got %h exp %h", obs, NOP_DECODE);
        end
        n_chk++;
        if ({out_pc_o, out_instr_o} !== 64'h0) begin
            n_err++; $display("FAIL reset_pc_instr: got %h/%h exp 0/0", out_pc_o, out_instr_o);
        end
    endtask

    task automatic test_load;
        rst_ni = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n_chk++;
        if ({out_valid_o, mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o} !== 5'b11011) begin
            n_err++;
            $display("FAIL load_flags: got v%b req%b we%b gpr%b wb%b exp 1 1 0 1 1",
                     out_valid_o, mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o);
        end
        n_chk++;
        if (mem_size_o !== LDST_W) begin
            n_err++; $display("FAIL load_size: got %0d exp %0d", mem_size_o, LDST_W);
        end
        n_chk++;
        if (out_pc_o !== 32'h0000_0100 || illegal_instr_o !== 1'b0) begin
            n_err++; $display("FAIL load_pc: got %h ill %b exp 00000100 ill 0",
                              out_pc_o, illegal_instr_o);
        end
        tick();
        n_chk++;
        if (out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL load_drain: got %b exp 0", out_valid_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [4];
        words[0] = 32'h0011_2223;
        words[1] = 32'h4020_8033;
        words[2] = 32'h0000_006F;
        words[3] = 32'h0020_8463;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_instr_i = words[i];
            in_pc_i    = 32'h300 + 32'(4 * i);
            tick();
            n_chk++;
            if (out_valid_o !== 1'b1 || out_pc_o !== 32'h300 + 32'(4 * i) ||
                    out_instr_o !== words[i] || in_ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_entry%0d: got v%b pc %h ins %h rdy %b exp 1 %h %h 1", i,
                         out_valid_o, out_pc_o, out_instr_o, in_ready_o,
                         32'h300 + 32'(4 * i), words[i]);
            end
            n_chk++;
            if (i == 0 && {mem_req_o, mem_we_o, gpr_we_a_o, ex_op_b_sel_o} !==
                    {3'b110, OP_B_IMM_S}) begin
                n_err++; $display("FAIL b2b_sw: got req%b we%b gpr%b b%0d exp 1 1 0 %0d",
                                  mem_req_o, mem_we_o, gpr_we_a_o, ex_op_b_sel_o, OP_B_IMM_S);
            end else if (i == 1 && {alu_op_o, ex_op_b_sel_o, gpr_we_a_o} !==
                    {ALU_SUB, OP_B_RS2, 1'b1}) begin
                n_err++; $display("FAIL b2b_sub: got alu%h b%0d gpr%b exp %h %0d 1",
                                  alu_op_o, ex_op_b_sel_o, gpr_we_a_o, ALU_SUB, OP_B_RS2);
            end else if (i == 2 && {jal_o, jalr_o, ex_op_a_sel_o, ex_op_b_sel_o, gpr_we_a_o}
                    !== {2'b10, OP_A_CURR_PC, OP_B_INCR, 1'b1}) begin
                n_err++; $display("FAIL b2b_jal: got jal%b jalr%b a%0d b%0d gpr%b exp 1 0 %0d %0d 1",
                                  jal_o, jalr_o, ex_op_a_sel_o, ex_op_b_sel_o, gpr_we_a_o,
                                  OP_A_CURR_PC, OP_B_INCR);
            end else if (i == 3 && {branch_o, alu_op_o, gpr_we_a_o} !== {1'b1, ALU_EQ, 1'b0}) begin
                n_err++; $display("FAIL b2b_beq: got br%b alu%h gpr%b exp 1 %h 0",
                                  branch_o, alu_op_o, gpr_we_a_o, ALU_EQ);
            end
        end
        in_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_illegal;
        logic [31:0] words [3];
        words[0] = 32'h0000_0000;
        words[1] = 32'h0000_3083;
        words[2] = 32'h0200_0033;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_instr_i = words[i];
            in_pc_i    = 32'h400 + 32'(4 * i);
            tick();
            n_chk++;
            if (illegal_instr_o !== 1'b1 || enables !== 12'h000 || out_valid_o !== 1'b1) begin
                n_err++; $display("FAIL illegal_%h: got ill %b en %h v %b exp 1 000 1",
                                  words[i], illegal_instr_o, enables, out_valid_o);
            end
        end
        in_instr_i = 32'h0FF0_000F;
        tick();
        in_valid_i = 1'b0;
        n_chk++;
        if (illegal_instr_o !== 1'b0 || enables !== 12'h000) begin
            n_err++; $display("FAIL fence_nop: got ill %b en %h exp 0 000",
                              illegal_instr_o, enables);
        end
        tick();
    endtask

    task automatic test_backpressure;
        logic [31:0] words [3];
        words[0] = 32'h0010_0093;
        words[1] = 32'h0020_0113;
        words[2] = 32'h0030_0193;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_instr_i  = words[0];
        in_pc_i     = 32'h200;
        tick();
        n_chk++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b1) begin
            n_err++; $display("FAIL bp_first: got rdy %b v %b exp 1 1", in_ready_o, out_valid_o);
        end
        in_instr_i = words[1];
        in_pc_i    = 32'h204;
        tick();
        n_chk++;
        if (in_ready_o !== 1'b0) begin
            n_err++; $display("FAIL bp_second_ready: got %b exp 0", in_ready_o);
        end
        in_instr_i = words[2];
        in_pc_i    = 32'h208;
        tick();
        n_chk++;
        if (out_pc_o !== 32'h200 || out_instr_o !== words[0] || in_ready_o !== 1'b0) begin
            n_err++; $display("FAIL bp_hold: got pc %h ins %h rdy %b exp 00000200 %h 0",
                              out_pc_o, out_instr_o, in_ready_o, words[0]);
        end
        out_ready_i = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            n_chk++;
            if (out_valid_o !== 1'b1 || out_pc_o !== 32'h200 + 32'(4 * i) ||
                    out_instr_o !== words[i] || in_ready_o !== 1'b1) begin
                n_err++; $display("FAIL bp_drain%0d: got v%b pc %h ins %h rdy %b exp 1 %h %h 1",
                                  i, out_valid_o, out_pc_o, out_instr_o, in_ready_o,
                                  32'h200 + 32'(4 * i), words[i]);
            end
            if (i == 1) begin
                in_valid_i = 1'b1;
            end else begin
                in_valid_i = 1'b0;
            end
        end
        tick();
        n_chk++;
        if (out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL bp_empty: got %b exp 0", out_valid_o);
        end
    endtask

    task automatic test_flush;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_instr_i  = 32'h0010_0093;
        in_pc_i     = 32'h4A0;
        tick();
        in_instr_i  = 32'h0020_0113;
        in_pc_i     = 32'h4A4;
        tick();
        n_chk++;
        if (in_ready_o !== 1'b0) begin
            n_err++; $display("FAIL flush_full: got rdy %b exp 0", in_ready_o);
        end
        in_instr_i = 32'h0040_0213;
        in_pc_i    = 32'h4D0;
        flush_i    = 1'b1;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        n_chk++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL flush_clear: got v %b rdy %b exp 0 1", out_valid_o, in_ready_o);
        end
        out_ready_i = 1'b1;
        tick();
        tick();
        n_chk++;
        if (out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL flush_dropped: got v %b pc %h exp 0", out_valid_o, out_pc_o);
        end
        in_valid_i = 1'b1;
        in_instr_i = 32'h0050_0293;
        in_pc_i    = 32'h4E0;
        tick();
        in_valid_i = 1'b0;
        n_chk++;
        if (out_valid_o !== 1'b1 || out_pc_o !== 32'h4E0) begin
            n_err++; $display("FAIL flush_resume: got v %b pc %h exp 1 000004e0",
                              out_valid_o, out_pc_o);
        end
        tick();
    endtask

    task automatic test_csr_system;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_instr_i  = 32'h3000_2073;
        in_pc_i     = 32'h500;
        tick();
        n_chk++;
        if (illegal_instr_o !== 1'b1 || csr_op_o !== 3'd0 || gpr_we_a_o !== 1'b0) begin
            n_err++; $display("FAIL csr_disabled: got ill %b op %0d gpr %b exp 1 0 0",
                              illegal_instr_o, csr_op_o, gpr_we_a_o);
        end
        n_chk++;
        if (c_illegal !== 1'b0 || c_csr_op !== 3'd2 || c_gpr_we !== 1'b1 || c_out_valid !== 1'b1)
        begin
            n_err++; $display("FAIL csr_enabled: got ill %b op %0d gpr %b v %b exp 0 2 1 1",
                              c_illegal, c_csr_op, c_gpr_we, c_out_valid);
        end
        in_instr_i = 32'h3020_0073;
        tick();
        n_chk++;
        if (mret_o !== 1'b1 || c_mret !== 1'b1 || illegal_instr_o !== 1'b0 || c_illegal !== 1'b0)
        begin
            n_err++; $display("FAIL mret: got %b/%b ill %b/%b exp 1/1 0/0",
                              mret_o, c_mret, illegal_instr_o, c_illegal);
        end
        in_instr_i = 32'h0000_0073;
        tick();
        n_chk++;
        if ({ecall_o, ebreak_o, mret_o, illegal_instr_o} !== 4'b1000) begin
            n_err++; $display("FAIL ecall: got e%b b%b m%b ill%b exp 1 0 0 0",
                              ecall_o, ebreak_o, mret_o, illegal_instr_o);
        end
        in_instr_i = 32'h0010_0073;
        tick();
        n_chk++;
        if ({ecall_o, ebreak_o, mret_o, illegal_instr_o} !== 4'b0100) begin
            n_err++; $display("FAIL ebreak: got e%b b%b m%b ill%b exp 0 1 0 0",
                              ecall_o, ebreak_o, mret_o, illegal_instr_o);
        end
        in_instr_i = 32'h0020_0073;
        tick();
        in_valid_i = 1'b0;
        n_chk++;
        if (illegal_instr_o !== 1'b1 || c_illegal !== 1'b1) begin
            n_err++; $display("FAIL system_other: got ill %b/%b exp 1/1",
                              illegal_instr_o, c_illegal);
        end
        tick();
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        test_reset();
        test_load();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_flush();
        test_csr_system();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
